// File: rtl/ram_bus_arbiter_if.sv
// Requester and RAM device signal bundle for ram_bus_arbiter.
// slave is the arbiter's view, master the board/requester side.
interface ram_bus_arbiter_if #(
  parameter int WORD_WIDTH = 32
);
  logic [1:0]            req;
  logic [1:0]            we;
  logic [WORD_WIDTH-1:0] addr0;
  logic [WORD_WIDTH-1:0] addr1;
  logic [WORD_WIDTH-1:0] wdata0;
  logic [WORD_WIDTH-1:0] wdata1;
  logic [1:0]            done;
  logic [1:0]            err;
  logic [WORD_WIDTH-1:0] rdata;
  logic [WORD_WIDTH-1:0] dev_stat;
  logic [WORD_WIDTH-1:0] dev_ctrl;
  logic [WORD_WIDTH-1:0] dev_addr;
  logic [WORD_WIDTH-1:0] dev_data_in;
  logic [WORD_WIDTH-1:0] dev_data_out;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1,
    input  dev_stat, dev_data_in,
    output done, err, rdata,
    output dev_ctrl, dev_addr, dev_data_out
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1,
    output dev_stat, dev_data_in,
    input  done, err, rdata,
    input  dev_ctrl, dev_addr, dev_data_out
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing the RAM device port between CPU and VGA.
// Runs the four-phase READ/WRITE/ACK handshake with an ACK timeout.
module ram_bus_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int READ_PIN   = 0,
  parameter int WRITE_PIN  = 1,
  parameter int ACK_PIN    = 0,
  parameter int TIMEOUT    = 1024
) (
  input logic              clk,
  input logic              rst,
  ram_bus_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RELEASE
  } state_e;

  state_e state_q, state_d;

  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdat_q, wdat_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            err_q, err_d;

  logic ack;
  logic start;
  logic sel;
  logic expired;

  assign ack     = bus.dev_stat[ACK_PIN];
  assign start   = (state_q == IDLE) && !ack && (bus.req != 2'b00);
  // Both pending: the one not served last; otherwise the only one.
  assign sel     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (start) state_d = WAIT_ACK;
      WAIT_ACK:     if (ack || expired) state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (!ack) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          gnt_d  = sel;
          last_d = sel;
          we_d   = bus.we[sel];
          cnt_d  = '0;
          addr_d = sel ? bus.addr1 : bus.addr0;
          wdat_d = '0;
          ctrl_d = '0;
          if (bus.we[sel]) begin
            wdat_d            = sel ? bus.wdata1 : bus.wdata0;
            ctrl_d[WRITE_PIN] = 1'b1;
          end else begin
            ctrl_d[READ_PIN] = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (ack) begin
          ctrl_d        = '0;
          done_d[gnt_q] = 1'b1;
          if (!we_q) rdata_d = bus.dev_data_in;
        end else if (expired) begin
          ctrl_d        = '0;
          done_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rdata        = rdata_q;
  assign bus.dev_ctrl     = ctrl_q;
  assign bus.dev_addr     = addr_q;
  assign bus.dev_data_out = wdat_q;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: directed cases then randomized batches
// against a transaction-level model of grants, memory and rdata.
module tb_ram_bus_arbiter;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
  } strobe_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  strobe_t     strobes[$];
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  bit          dev_auto, dev_dead, man_ack, len_chk;
  int          ack_dly, rel_dly;
  int          last;
  logic [31:0] exp_rdata;
  logic        r_we   [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wd   [2];

  ram_bus_arbiter_if #(.WORD_WIDTH(32)) bus ();

  ram_bus_arbiter #(
    .WORD_WIDTH(32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Device: four-phase responder with configurable ACK / release delays.
  initial begin : device
    int c;
    c = 0;
    bus.dev_stat    = $urandom & ~32'h1;
    bus.dev_data_in = $urandom;
    forever begin
      @(negedge clk);
      #1;
      bus.dev_data_in = $urandom;
      if (!dev_auto) begin
        c = 0;
        bus.dev_stat[0] = man_ack;
      end else if (bus.dev_ctrl[1:0] != 2'b00 && !bus.dev_stat[0]) begin
        if (!dev_dead) begin
          if (c >= ack_dly) begin
            c = 0;
            bus.dev_stat[0] = 1'b1;
            if (bus.dev_ctrl[1]) dev_mem[bus.dev_addr] = bus.dev_data_out;
            else if (dev_mem.exists(bus.dev_addr))
              bus.dev_data_in = dev_mem[bus.dev_addr];
            else bus.dev_data_in = dflt(bus.dev_addr);
          end else c++;
        end
      end else if (bus.dev_ctrl[1:0] == 2'b00 && bus.dev_stat[0]) begin
        if (c >= rel_dly) begin
          c = 0;
          bus.dev_stat[0] = 1'b0;
        end else c++;
      end
    end
  end

  // Strobe monitor plus per-cycle bus invariants.
  initial begin : monitor
    logic [31:0] prev;
    logic        a;
    strobe_t     s;
    int          len;
    prev = '0;
    len  = 0;
    forever begin
      @(posedge clk);
      a = bus.dev_stat[0];
      #2;
      chk("ctrl_unused_bits", bus.dev_ctrl & ~32'h3, 32'h0);
      chk("pins_exclusive", 32'(&bus.dev_ctrl[1:0]), 32'h0);
      chk("done_onehot", 32'(bus.done == 2'b11), 32'h0);
      chk("err_without_done", 32'(bus.err & ~bus.done), 32'h0);
      if (bus.dev_ctrl != 0 && prev == 0) begin
        chk("grant_ack_low", 32'(a), 32'h0);
        s.ctrl = bus.dev_ctrl;
        s.addr = bus.dev_addr;
        s.data = bus.dev_data_out;
        len    = 0;
      end
      if (bus.dev_ctrl != 0) len++;
      else if (prev != 0) begin
        s.len = len;
        strobes.push_back(s);
      end
      prev = bus.dev_ctrl;
    end
  end

  task automatic set_req(input int g, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
    r_we[g]   = w;
    r_addr[g] = a;
    r_wd[g]   = d;
    bus.we[g] = w;
    if (g == 0) begin
      bus.addr0  = a;
      bus.wdata0 = d;
    end else begin
      bus.addr1  = a;
      bus.wdata1 = d;
    end
  endtask

  task automatic rand_req(input int g);
    set_req(g, 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 15)) << 2, $urandom);
  endtask

  task automatic expect_txn(input int g);
    int          t;
    strobe_t     s;
    logic [31:0] a;
    t = 0;
    while (bus.done == 2'b00 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_within_bound", 32'(t < 100), 32'h1);
    chk("done", 32'(bus.done), 32'(1) << g);
    chk("err", 32'(bus.err), dev_dead ? (32'(1) << g) : 32'h0);
    chk("strobe_count", 32'(strobes.size()), 32'h1);
    if (strobes.size() > 0) begin
      s = strobes.pop_front();
      chk("pin", s.ctrl, r_we[g] ? 32'd2 : 32'd1);
      chk("dev_addr", s.addr, r_addr[g]);
      chk("dev_data_out", s.data, r_we[g] ? r_wd[g] : 32'h0);
      if (len_chk)
        chk("strobe_len", 32'(s.len), dev_dead ? 32'(TIMEOUT) : 32'(ack_dly + 1));
    end
    a = r_addr[g];
    if (!dev_dead) begin
      if (r_we[g]) ref_mem[a] = r_wd[g];
      else exp_rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    end
    chk("rdata", bus.rdata, exp_rdata);
  endtask

  task automatic run_batch(input int n0, input int n1, input bit preset,
                           input bit chk_lat);
    int rem [2];
    int g;
    bit first;
    rem[0] = n0;
    rem[1] = n1;
    first  = 1'b1;
    if (!preset) begin
      if (n0 > 0) rand_req(0);
      if (n1 > 0) rand_req(1);
    end
    bus.req[0] = (rem[0] > 0);
    bus.req[1] = (rem[1] > 0);
    while (rem[0] + rem[1] > 0) begin
      g = (rem[0] > 0 && rem[1] > 0) ? 1 - last : (rem[0] > 0 ? 0 : 1);
      last = g;
      if (first && chk_lat) begin
        @(negedge clk);
        chk("req_to_strobe", bus.dev_ctrl, r_we[g] ? 32'd2 : 32'd1);
      end
      first = 1'b0;
      expect_txn(g);
      rem[g]--;
      if (rem[g] > 0) rand_req(g);
      else bus.req[g] = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'h0);
      chk("err_one_cycle", 32'(bus.err), 32'h0);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    strobes.delete();
    last      = 1;
    exp_rdata = '0;
  endtask

  initial begin
    int n0, n1, prev_rel;
    vectors     = 0;
    miscompares = 0;
    dev_auto    = 1'b1;
    dev_dead    = 1'b0;
    man_ack     = 1'b0;
    len_chk     = 1'b1;
    ack_dly     = 0;
    rel_dly     = 0;
    last        = 1;
    exp_rdata   = '0;
    rst         = 1'b1;
    bus.req     = 2'b00;
    set_req(0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 32'h0, 32'h0);

    @(negedge clk);
    chk("rst_dev_ctrl", bus.dev_ctrl, 32'h0);
    chk("rst_dev_addr", bus.dev_addr, 32'h0);
    chk("rst_dev_data_out", bus.dev_data_out, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    strobes.delete();
    @(negedge clk);

    // Single read, ACK two cycles after the strobe.
    ack_dly = 2;
    dev_mem[32'h10] = 32'hCAFE;
    ref_mem[32'h10] = 32'hCAFE;
    set_req(0, 1'b0, 32'h10, 32'h1234);
    run_batch(1, 0, 1'b1, 1'b1);
    chk("read_cafe", bus.rdata, 32'hCAFE);

    // Single write with slow ACK release, then read it back.
    ack_dly = 0;
    rel_dly = 3;
    set_req(1, 1'b1, 32'h7C, 32'h200041);
    run_batch(0, 1, 1'b1, 1'b1);
    set_req(0, 1'b0, 32'h7C, 32'h0);
    run_batch(1, 0, 1'b1, 1'b0);
    chk("readback_7c", bus.rdata, 32'h200041);

    // Contention after reset: grants 0,1,0,1.
    rel_dly = 0;
    repeat (6) @(negedge clk);
    pulse_reset();
    ack_dly = 1;
    run_batch(2, 2, 1'b0, 1'b1);

    // Dead device: timeout, then the next request is served.
    dev_dead = 1'b1;
    set_req(0, 1'b0, 32'h10, 32'h0);
    run_batch(1, 0, 1'b1, 1'b1);
    dev_dead = 1'b0;
    run_batch(1, 1, 1'b0, 1'b1);

    // Stale ACK: no grant until it falls.
    dev_auto = 1'b0;
    man_ack  = 1'b1;
    set_req(1, 1'b1, 32'h30, $urandom);
    bus.req = 2'b10;
    repeat (3) begin
      @(negedge clk);
      chk("stale_ack_no_strobe", bus.dev_ctrl, 32'h0);
    end
    man_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stale_ack_strobe", bus.dev_ctrl, 32'h2);
    len_chk  = 1'b0;
    dev_auto = 1'b1;
    run_batch(0, 1, 1'b1, 1'b0);
    len_chk = 1'b1;

    // Reset in WAIT_ACK, then the held request is served.
    repeat (3) @(negedge clk);
    dev_auto = 1'b0;
    man_ack  = 1'b0;
    set_req(0, 1'b0, 32'h44, 32'h0);
    bus.req = 2'b01;
    @(negedge clk);
    chk("pre_rst_strobe", bus.dev_ctrl, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", bus.dev_ctrl, 32'h0);
    chk("async_rst_done", 32'(bus.done), 32'h0);
    chk("async_rst_addr", bus.dev_addr, 32'h0);
    @(negedge clk);
    chk("rst_no_done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    strobes.delete();
    last      = 1;
    exp_rdata = '0;
    dev_auto  = 1'b1;
    run_batch(1, 0, 1'b1, 1'b1);

    // Randomized batches.
    repeat (4) @(negedge clk);
    prev_rel = 0;
    for (int i = 0; i < 30; i++) begin
      ack_dly  = $urandom_range(0, 3);
      rel_dly  = $urandom_range(0, 2);
      dev_dead = ($urandom_range(0, 7) == 0);
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 + n1 == 0) n0 = 1;
      run_batch(n0, n1, 1'b0, (rel_dly == 0) && (prev_rel == 0));
      prev_rel = rel_dly;
    end
    dev_dead = 1'b0;

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single RAM device port (ctrl pins, stat ACK, addr, data) between two requesters: requester 0 (CPU load/store) and requester 1 (VGA refresh/copy engine).
- Runs the device's four-phase handshake: assert the READ or WRITE pin, wait for ACK high, drop the pin, wait for ACK low.
- Uses round-robin arbitration.
- Has a per-transaction ACK timeout, so a dead device cannot hang the board state machine.
- Sits on the motherboard between the requesters and the ram_ctrl/ram_stat/addr/data bus.

Parameters:
- WORD_WIDTH, 32, width of addr, data, ctrl and stat words.
- READ_PIN, 0, bit index of the read strobe in dev_ctrl.
- WRITE_PIN, 1, bit index of the write strobe in dev_ctrl.
- ACK_PIN, 0, bit index of ACK in dev_stat.
- TIMEOUT, 1024, maximum number of cycles spent waiting for ACK high before aborting.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req  in  2  per-requester request level
- we  in  2  per-requester write enable (1 = write, 0 = read)
- addr0, addr1  in  WORD_WIDTH  request address
- wdata0, wdata1  in  WORD_WIDTH  write data
- done  out  2  one-cycle completion pulse, per requester
- err  out  2  one-cycle timeout flag, coincident with done
- rdata  out  WORD_WIDTH  read data, held until the next completed read
- dev_stat  in  WORD_WIDTH  device status word (ACK at ACK_PIN)
- dev_ctrl  out  WORD_WIDTH  device control word
- dev_addr  out  WORD_WIDTH  device address
- dev_data_in  in  WORD_WIDTH  data returned by the device
- dev_data_out  out  WORD_WIDTH  data sent to the device

Behaviour:
- Clocking and reset:
  - clk is the clock. rst is asynchronous and active-high.
  - All outputs are registered.
  - Reset values: dev_ctrl, dev_addr, dev_data_out, rdata = 0; done = err = 0; state = IDLE; last_grant = 1 (so requester 0 wins first); timeout counter = 0.
- Requester contract:
  - Hold req[i], we[i], addr_i and wdata_i stable until done[i] pulses.
  - If req[i] is still high in the cycle after done[i], it is a new request.
- State IDLE:
  - Waits for ACK low and req != 0.
  - On such an edge, selects the grantee g:
    - only one request pending: that requester;
    - both pending: the requester != last_grant.
  - On that edge: latch g, set last_grant = g, drive dev_addr = addr_g and dev_data_out = wdata_g (write) or 0 (read), set exactly one pin (WRITE_PIN if we[g], else READ_PIN), clear the counter, go to WAIT_ACK.
  - Request-to-strobe latency is one edge.
- State WAIT_ACK:
  - Each edge with ACK low increments the counter.
  - Edge sampling ACK high:
    - dev_ctrl = 0; done[g] = 1;
    - read: rdata = dev_data_in;
    - go to WAIT_RELEASE.
  - Edge where the counter reaches TIMEOUT-1 with ACK still low:
    - dev_ctrl = 0; done[g] = 1; err[g] = 1; rdata unchanged;
    - go to WAIT_RELEASE.
- State WAIT_RELEASE:
  - Stays until ACK is sampled low, then goes to IDLE.
  - dev_addr and dev_data_out are held until IDLE regrants.
- Pulses and ordering:
  - done and err are high for exactly one cycle.
  - Only one bit of done is ever set at a time.
- Back-to-back: minimum transaction is 3 edges with an immediate ACK (IDLE→WAIT_ACK→WAIT_RELEASE→IDLE). A requester left waiting is served next; no starvation.
- Requests outside IDLE: a request arriving while busy waits in req; it is not lost.
- Retraction:
  - Dropping req before done is illegal.
  - The transaction completes anyway and done still pulses.
- ACK already high in IDLE (stale from a previous master): no grant until it falls.
- Reset mid-transaction:
  - The pin drops immediately (asynchronous), state returns to IDLE, no done is issued.
  - The first post-reset grant waits for ACK low.
- Unused dev_ctrl bits are always 0. The read and write pins are never high together.

Test Plan:
- Single read: req=01, we=0, addr0=0x10; device ACKs 2 cycles after READ_PIN, dev_data_in=0xCAFE -> READ_PIN high 1 edge after req, dev_addr=0x10, done=01 for 1 cycle, rdata=0xCAFE, err=00.
- Single write: req=10, we=10, addr1=0x7C, wdata1=0x200041 -> WRITE_PIN high, dev_data_out=0x200041, done=10 after ACK, then IDLE only after ACK falls.
- Contention: req=11 held continuously, ACK 1 cycle after each strobe -> grants alternate 0,1,0,1 over 4 transactions; first grant goes to requester 0 after reset.
- Timeout: TIMEOUT=8, device never ACKs -> strobe drops on the 8th WAIT_ACK edge, done=01 and err=01 for 1 cycle, rdata unchanged, next request accepted.
- Stale ACK: ACK held high at start, req=01 -> no strobe until ACK low, strobe on the following edge.
- Reset mid-op: assert rst while in WAIT_ACK with READ_PIN high -> dev_ctrl=0 asynchronously, done=00, after release a pending req=01 is serviced normally.
